kyber_shiftadd_mult: RTL and testbench
======================================

KYBER_SHIFTADD_MULT -- requirements
Module: kyber_shiftadd_mult

Interface
REQ-001 The block SHALL provide clk_i, input, 1 bit: rising-edge clock.
REQ-002 The block SHALL provide rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-003 The block SHALL provide in_valid_i, input, 1 bit: operand pair valid.
REQ-004 The block SHALL provide in_ready_o, output, 1 bit: block can accept an operand pair.
REQ-005 The block SHALL provide a_i, input, DATA_LENGTH bits: operand a; only bits [11:0] are used.
REQ-006 The block SHALL provide b_i, input, DATA_LENGTH bits: operand b; only bits [11:0] are used.
REQ-007 The block SHALL provide out_valid_o, output, 1 bit: product valid.
REQ-008 The block SHALL provide out_ready_i, input, 1 bit: downstream reduction stage accepts the product.
REQ-009 The block SHALL provide result_o, output, DATA_LENGTH bits: product a[11:0]*b[11:0], zero-extended; this feeds x_i of the reduction stage.

Function
REQ-010 The block SHALL implement a 3-state FSM: IDLE, CALC, DONE.
REQ-011 in_ready_o SHALL be 1 only in IDLE; out_valid_o SHALL be 1 only in DONE.
REQ-012 An input transfer SHALL occur on an edge with in_valid_i=1 in IDLE. It SHALL latch a_i[11:0] and b_i[11:0], clear the 24-bit accumulator and the 4-bit counter, and enter CALC.
REQ-013 Each CALC edge SHALL compute acc = (acc<<1) + (b[11-cnt] ? a : 0), processing b MSB-first, and then increment cnt.
REQ-014 On the CALC edge where cnt=11, the block SHALL write the final accumulator value to result_o and enter DONE.
REQ-015 out_valid_o SHALL be visible in the cycle after the 12th CALC edge, i.e. a fixed latency of 12 cycles from the accepting edge.
REQ-016 In DONE, the block SHALL return to IDLE on the edge where out_ready_i=1 and hold DONE otherwise.
REQ-017 result_o SHALL stay stable while out_valid_o=1 and out_ready_i=0.
REQ-018 result_o SHALL change only on DONE entry and SHALL hold its last value in IDLE and CALC.
REQ-019 in_valid_i, a_i and b_i SHALL be ignored outside IDLE; operand changes during CALC SHALL not affect the result.
REQ-020 Arithmetic SHALL be unsigned and 24 bits wide with no overflow (max 4095*4095=16769025 < 2^24); result_o bits [DATA_LENGTH-1:24] SHALL be 0.
REQ-021 Operand bits [DATA_LENGTH-1:12] SHALL be ignored.
REQ-022 The minimum initiation interval SHALL be 14 cycles: accept, 12 CALC cycles, then 1 DONE cycle with out_ready_i=1. IDLE follows, and the next accept can occur on that edge.

Reset
REQ-023 Asserting rst_i SHALL immediately force IDLE with in_ready_o=1, out_valid_o=0, result_o=0, accumulator=0, cnt=0 and latched operands=0, independent of clk_i.
REQ-024 Reset asserted during CALC or DONE SHALL abort the operation with no product delivered.
REQ-025 Within the first clock edge after deassertion, the block SHALL accept a new operand pair.

Structure
REQ-026 The shared package multiplier_pkg SHALL hold DATA_LENGTH (>=24), KYBER_COEFF_W=12, KYBER_PROD_W=24 and the FSM state enum typedef.
REQ-027 The block SHALL contain no sub-module; the shift-add datapath, counter and FSM SHALL be implemented inline.
REQ-028 The reduction stage SHALL be instantiated by the parent, connecting result_o to its x_i.

Verification
REQ-029 The bench SHALL apply a=3328, b=3328 with out_ready_i=1 -> out_valid_o exactly 12 cycles after accept, result_o=11075584.
REQ-030 The bench SHALL apply a=4095, b=4095 -> result_o=16769025; apply a=0, b=1234 -> result_o=0.
REQ-031 The bench SHALL apply a=32'hFFFFF001, b=32'h00000002 -> result_o=2, confirming upper bits are ignored.
REQ-032 The bench SHALL hold out_ready_i=0 for 5 cycles after out_valid_o -> out_valid_o and result_o stay stable, in_ready_o stays 0, and a new in_valid_i is not accepted.
REQ-033 The bench SHALL assert rst_i mid-edge at CALC cnt=6 -> all outputs reach reset values without a clock; after release, a=17, b=3 -> result_o=51.
REQ-034 The bench SHALL drive back-to-back pairs (100,200) and (3329,1) with in_valid_i held high -> products 20000 then 3329, with the second accept exactly 14 cycles after the first.

Source files
------------

// File: rtl/multiplier_pkg.sv
// Shared constants and FSM state type for the Kyber coefficient multiplier.
package multiplier_pkg;

  localparam int unsigned DATA_LENGTH   = 32;
  localparam int unsigned KYBER_COEFF_W = 12;
  localparam int unsigned KYBER_PROD_W  = 24;
  localparam int unsigned CNT_W         = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } mult_state_e;

endpackage

// File: rtl/kyber_shiftadd_mult.sv
// Sequential 12x12 shift-add multiplier, b processed MSB-first, one bit per cycle.
// Result feeds the x_i input of the downstream reduction stage.
module kyber_shiftadd_mult
  import multiplier_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [DATA_LENGTH-1:0] a_i,
  input  logic [DATA_LENGTH-1:0] b_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [DATA_LENGTH-1:0] result_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KYBER_COEFF_W - 1);

  mult_state_e               state;
  logic [KYBER_COEFF_W-1:0]  a_q;
  logic [KYBER_COEFF_W-1:0]  b_q;
  logic [KYBER_PROD_W-1:0]   acc;
  logic [CNT_W-1:0]          cnt;
  logic [KYBER_PROD_W-1:0]   acc_nxt_c;
  logic                      b_bit_c;

  // One shift-add step; cnt counts up so CNT_LAST - cnt walks b from MSB to LSB.
  always_comb begin
    b_bit_c   = b_q[CNT_LAST - cnt];
    acc_nxt_c = (acc << 1) + (b_bit_c ? KYBER_PROD_W'(a_q) : '0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      in_ready_o  <= 1'b1;
      out_valid_o <= 1'b0;
      result_o    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc         <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid_i) begin
            a_q        <= a_i[KYBER_COEFF_W-1:0];
            b_q        <= b_i[KYBER_COEFF_W-1:0];
            acc        <= '0;
            cnt        <= '0;
            in_ready_o <= 1'b0;
            state      <= ST_CALC;
          end
        end
        ST_CALC: begin
          acc <= acc_nxt_c;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            result_o    <= DATA_LENGTH'(acc_nxt_c);
            out_valid_o <= 1'b1;
            state       <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            in_ready_o  <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: begin
          out_valid_o <= 1'b0;
          in_ready_o  <= 1'b1;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kyber_shiftadd_mult.sv
// Randomized self-checking bench for kyber_shiftadd_mult against an arithmetic reference.
module tb_kyber_shiftadd_mult;
  import multiplier_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic [DATA_LENGTH-1:0] a_in;
  logic [DATA_LENGTH-1:0] b_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_LENGTH-1:0] result;

  int total = 0;
  int bad   = 0;

  kyber_shiftadd_mult dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .a_i        (a_in),
    .b_i        (b_in),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .result_o   (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: product of the low 12 bits of each operand.
  function automatic logic [63:0] ref_prod(input logic [DATA_LENGTH-1:0] a, input logic [DATA_LENGTH-1:0] b);
    return 64'(a % 4096) * 64'(b % 4096);
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("ready_wait", 64'(in_ready), 64'(1));
  endtask

  // Full transaction: accept, latency and stability checks, optional backpressure, release.
  task automatic run_op(input logic [DATA_LENGTH-1:0] a, input logic [DATA_LENGTH-1:0] b, input int hold);
    int n;
    logic [DATA_LENGTH-1:0] prev;
    logic [DATA_LENGTH-1:0] r;
    wait_ready();
    prev     = result;
    in_valid = 1'b1;
    a_in     = a;
    b_in     = b;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    chk("accepted", 64'(in_ready), 64'(0));
    in_valid = 1'($urandom_range(0, 1));
    n = 0;
    while (!out_valid && n < 40) begin
      chk("calc_result_hold", 64'(result), 64'(prev));
      a_in = $urandom;
      b_in = $urandom;
      @(posedge clk); #1; n++;
    end
    chk("latency", 64'(n), 64'(12));
    chk("product", 64'(result), ref_prod(a, b));
    chk("upper_zero", 64'(result >> KYBER_PROD_W), 64'(0));
    r = result;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      @(posedge clk); #1;
      chk("hold_valid", 64'(out_valid), 64'(1));
      chk("hold_result", 64'(result), 64'(r));
      chk("hold_ready", 64'(in_ready), 64'(0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release_valid", 64'(out_valid), 64'(0));
    chk("release_ready", 64'(in_ready), 64'(1));
    chk("idle_result", 64'(result), 64'(r));
  endtask

  initial begin
    int n;
    int first_ready;
    bit got1;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a_in = '0; b_in = '0;
    #2;
    chk("rst_ready", 64'(in_ready), 64'(1));
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_result", 64'(result), 64'(0));
    @(posedge clk); @(negedge clk);
    rst = 1'b0;

    run_op(32'd3328, 32'd3328, 0);
    chk("known_3328sq", 64'(result), 64'(11075584));
    run_op(32'd4095, 32'd4095, 0);
    chk("known_max", 64'(result), 64'(16769025));
    run_op(32'd0, 32'd1234, 0);
    chk("known_zero", 64'(result), 64'(0));
    run_op(32'hFFFFF001, 32'h00000002, 0);
    chk("known_upper_ignored", 64'(result), 64'(2));
    run_op(32'd1234, 32'd2345, 5);

    // Abort mid-computation: reset takes effect between clock edges.
    wait_ready();
    in_valid = 1'b1; a_in = 32'd3000; b_in = 32'd4000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
    end
    #1 rst = 1'b1;
    #1;
    chk("abort_ready", 64'(in_ready), 64'(1));
    chk("abort_valid", 64'(out_valid), 64'(0));
    chk("abort_result", 64'(result), 64'(0));
    @(posedge clk); @(negedge clk);
    chk("abort_no_product", 64'(out_valid), 64'(0));
    rst = 1'b0;
    run_op(32'd17, 32'd3, 0);
    chk("after_reset_51", 64'(result), 64'(51));

    // Back-to-back accepts with in_valid held high.
    wait_ready();
    in_valid = 1'b1; out_ready = 1'b1; a_in = 32'd100; b_in = 32'd200;
    @(posedge clk); #1;
    a_in = 32'd3329; b_in = 32'd1;
    n = 0; first_ready = -1; got1 = 1'b0;
    while (first_ready < 0 && n < 40) begin
      @(posedge clk); #1; n++;
      if (out_valid && !got1) begin
        got1 = 1'b1;
        chk("b2b_first_lat", 64'(n), 64'(12));
        chk("b2b_first", 64'(result), 64'(20000));
      end
      if (in_ready) first_ready = n;
    end
    chk("b2b_first_seen", 64'(got1), 64'(1));
    @(posedge clk); #1; n++;
    chk("b2b_second_accept", 64'(in_ready), 64'(0));
    chk("b2b_interval", 64'(n), 64'(14));
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("b2b_second_lat", 64'(n), 64'(12));
    chk("b2b_second", 64'(result), 64'(3329));
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("b2b_idle", 64'(in_ready), 64'(1));

    for (int k = 0; k < 25; k++) begin
      run_op($urandom, $urandom, int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
